// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the multi-port GPR file.
//               - rf_state_e : clear-sweep / ready state encoding
//               - wr_hit()   : finds the winning (highest-index) enabled write
//                              port that targets a given address; used for
//                              write priority, read bypass and busy clearing.
//               Port-facing vectors are zero-padded to RF_MAX_WR ports and
//               RF_MAX_ADDR_W address bits before calling wr_hit(), so one
//               function serves every parameterisation up to those limits.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_ADDR_W     = 5;
  localparam int RF_MAX_WR     = 8;
  localparam int RF_MAX_ADDR_W = 16;
  localparam int RF_WR_IDX_W   = $clog2(RF_MAX_WR);

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  typedef struct packed {
    logic                   hit;
    logic [RF_WR_IDX_W-1:0] idx;
  } wr_hit_t;

  // Ascending scan: a later (higher-index) match overwrites an earlier one,
  // so the highest-index enabled port wins.
  function automatic wr_hit_t wr_hit(
    input logic [RF_MAX_WR-1:0]               en,
    input logic [RF_MAX_WR*RF_MAX_ADDR_W-1:0] addrs,
    input logic [RF_MAX_ADDR_W-1:0]           addr
  );
    wr_hit_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int k = 0; k < RF_MAX_WR; k++) begin
      if (en[k] && (addrs[k*RF_MAX_ADDR_W +: RF_MAX_ADDR_W] == addr)) begin
        r.hit = 1'b1;
        r.idx = k[RF_WR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy flags for the GPR file.
//               Ports:
//                 clk, rst      clock / synchronous active-high reset
//                 active        high when the register file is READY; while
//                               low, issue/flush/writes are ignored and
//                               rd_busy reads 0
//                 wr_en/wr_addr write ports (a write clears busy[addr])
//                 issue_en/addr sets busy[issue_addr] (wins over a write)
//                 flush         clears every busy bit (wins over everything)
//                 rd_en/rd_addr read ports looked up for rd_busy
//                 rd_busy       busy flag, masked by a same-cycle write so it
//                               agrees with the data bypass
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     active,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]                     r_busy;
  logic [RF_MAX_WR-1:0]                 w_wen_pad;
  logic [RF_MAX_WR*RF_MAX_ADDR_W-1:0]   w_waddr_pad;
  wr_hit_t                              w_wsel [DEPTH];
  logic [DEPTH*RF_WR_IDX_W-1:0]         w_unused_idx;

  always_comb begin
    w_wen_pad   = '0;
    w_waddr_pad = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_wen_pad[k] = wr_en[k] & active;
      w_waddr_pad[k*RF_MAX_ADDR_W +: ADDR_W] = wr_addr[k*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wsel[i] = wr_hit(w_wen_pad, w_waddr_pad, RF_MAX_ADDR_W'(i));
      w_unused_idx[i*RF_WR_IDX_W +: RF_WR_IDX_W] = w_wsel[i].idx;
    end
  end

  // busy[0] is never set, so it stays 0 from reset onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else if (active) begin
      if (flush) begin
        r_busy <= '0;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          if (w_wsel[i].hit) begin
            r_busy[i] <= 1'b0;
          end
        end
        // Issued after the clears so a new producer overrides a retiring one.
        if (issue_en && (issue_addr != '0)) begin
          r_busy[issue_addr] <= 1'b1;
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_busy
    logic [ADDR_W-1:0] w_addr;
    wr_hit_t           w_hit;
    logic              w_unused_hit_idx;

    assign w_addr           = rd_addr[j*ADDR_W +: ADDR_W];
    assign w_hit            = wr_hit(w_wen_pad, w_waddr_pad, RF_MAX_ADDR_W'(w_addr));
    assign w_unused_hit_idx = ^w_hit.idx;
    assign rd_busy[j]       = active && rd_en[j] && (w_addr != '0) &&
                              r_busy[w_addr] && !w_hit.hit;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Parametrised multi-port GPR file with busy scoreboard and a
//               post-reset clear sweep. Register 0 reads as zero.
//               Ports:
//                 clk, rst        clock / synchronous active-high reset
//                 init_done       high once the clear sweep has finished
//                 wr_en/addr/data NUM_WR write ports, higher index wins
//                 rd_en/addr      NUM_RD read ports
//                 rd_data         combinational read data with write bypass
//                 rd_busy         combinational pending-write flag
//                 issue_en/addr   mark a destination register busy
//                 flush           clear all busy flags
//               NUM_WR must not exceed RF_MAX_WR and ADDR_W must not exceed
//               RF_MAX_ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};

  rf_state_e                          r_state;
  logic [ADDR_W-1:0]                  r_idx;
  logic                               r_init_done;
  logic [DATA_W-1:0]                  r_mem [DEPTH];

  logic                               w_ready;
  logic [RF_MAX_WR-1:0]               w_wen_pad;
  logic [RF_MAX_WR*RF_MAX_ADDR_W-1:0] w_waddr_pad;
  logic [RF_MAX_WR*DATA_W-1:0]        w_wdata_pad;
  wr_hit_t                            w_wsel [DEPTH];

  assign w_ready   = (r_state == RF_READY);
  assign init_done = r_init_done;

  // Write ports are masked while sweeping so the sweep owns the array.
  always_comb begin
    w_wen_pad   = '0;
    w_waddr_pad = '0;
    w_wdata_pad = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_wen_pad[k] = wr_en[k] & w_ready;
      w_waddr_pad[k*RF_MAX_ADDR_W +: ADDR_W] = wr_addr[k*ADDR_W +: ADDR_W];
      w_wdata_pad[k*DATA_W +: DATA_W]        = wr_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wsel[i] = wr_hit(w_wen_pad, w_waddr_pad, RF_MAX_ADDR_W'(i));
    end
  end

  // Sweep FSM: the reset cycle only arms the sweep; index 1 is written on
  // the following edge and the transition happens on the edge writing the
  // last index, giving DEPTH-1 cycles with init_done low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RF_CLEAR;
      r_idx       <= IDX_ONE;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_idx <= r_idx + IDX_ONE;
          if (r_idx == IDX_LAST) begin
            r_state     <= RF_READY;
            r_init_done <= 1'b1;
          end
        end
        RF_READY: begin
          r_init_done <= 1'b1;
        end
        default: begin
          r_state     <= RF_CLEAR;
          r_idx       <= IDX_ONE;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Data array. Entry 0 is never written and never read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RF_CLEAR) begin
        r_mem[r_idx] <= '0;
      end else begin
        for (int i = 1; i < DEPTH; i++) begin
          if (w_wsel[i].hit) begin
            r_mem[i] <= w_wdata_pad[w_wsel[i].idx*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    wr_hit_t           w_hit;
    logic [DATA_W-1:0] w_data;

    assign w_addr = rd_addr[j*ADDR_W +: ADDR_W];
    assign w_hit  = wr_hit(w_wen_pad, w_waddr_pad, RF_MAX_ADDR_W'(w_addr));

    always_comb begin
      w_data = '0;
      if (w_ready && rd_en[j] && (w_addr != '0)) begin
        if (w_hit.hit) begin
          w_data = w_wdata_pad[w_hit.idx*DATA_W +: DATA_W];
        end else begin
          w_data = r_mem[w_addr];
        end
      end
    end

    assign rd_data[j*DATA_W +: DATA_W] = w_data;
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .active     (w_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_busy    (rd_busy)
  );

endmodule
`default_nettype wire
